// File: rtl/varwidth_fifo_reader_if.sv
// rtl/varwidth_fifo_reader_if.sv - RAM read port and output sample stream of the capture FIFO reader
//
// Purpose: bundles the two buses the reader talks on.
//   RAM read port : bram_rd_addr, bram_rd_ws, bram_rd_ce (reader -> RAM),
//                   bram_rd_data (RAM -> reader, valid 1 cycle after ce)
//   Sample stream : dout, dout_valid (reader -> host), dout_ready (host -> reader)
// Modports:
//   master : the reader side
//   slave  : the RAM / host side
interface varwidth_fifo_reader_if #(
  parameter int addr_width    = 11,
  parameter int rd_data_width = 8
);
  logic [addr_width-1:0]    bram_rd_addr;
  logic [4:0]               bram_rd_ws;
  logic                     bram_rd_ce;
  logic [rd_data_width-1:0] bram_rd_data;
  logic [rd_data_width-1:0] dout;
  logic                     dout_valid;
  logic                     dout_ready;

  modport master (
    output bram_rd_addr, bram_rd_ws, bram_rd_ce, dout, dout_valid,
    input  bram_rd_data, dout_ready
  );

  modport slave (
    input  bram_rd_addr, bram_rd_ws, bram_rd_ce, dout, dout_valid,
    output bram_rd_data, dout_ready
  );
endinterface

// File: rtl/varwidth_fifo_reader.sv
// rtl/varwidth_fifo_reader.sv - read-side sequencer replaying a finished variable-width capture
//
// Purpose: replays a capture oldest-first. Segment A is the circular
// pre-trigger region (wraps from (seg_a_last, last ws) to (0,0)); segment B
// is the linear post-trigger region starting at ws 0. Samples leave on a
// valid/ready stream through a 2-entry skid buffer.
// Ports:
//   clk, rst_n          read clock, synchronous active-low reset
//   start               one-cycle pulse, latches seg_* and starts (ignored while busy)
//   seg_a_addr/ws/last  segment A first slot and circular-region end address
//   seg_a_len           slots in A (0 = skip)
//   seg_b_addr/len      segment B first address and slot count (0 = skip)
//   bus (master)        RAM read port and output sample stream
//   busy                readout in progress
//   done                one-cycle pulse after the final sample is accepted
module varwidth_fifo_reader #(
  parameter int addr_width       = 11,
  parameter int rd_data_width    = 8,
  parameter int rd_data_per_addr = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [addr_width-1:0] seg_a_addr,
  input  logic [4:0]            seg_a_ws,
  input  logic [addr_width-1:0] seg_a_last,
  input  logic [31:0]           seg_a_len,
  input  logic [addr_width-1:0] seg_b_addr,
  input  logic [31:0]           seg_b_len,
  varwidth_fifo_reader_if.master bus,
  output logic                  busy,
  output logic                  done
);

  localparam logic [4:0] WS_MAX = 5'(rd_data_per_addr - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEG_A,
    SEG_B,
    DRAIN
  } state_t;

  state_t state, state_n;

  // Read pointer and latched segment configuration
  logic [addr_width-1:0]    rd_addr;
  logic [4:0]               rd_ws;
  logic [addr_width-1:0]    a_last;
  logic [addr_width-1:0]    b_addr;
  logic [31:0]              b_len;
  logic [31:0]              remaining;

  // A read issued last cycle whose data is on bram_rd_data now
  logic                     rd_pending;

  // Skid buffer: head is the registered output, tail absorbs one extra sample
  logic [rd_data_width-1:0] head_data;
  logic                     head_valid;
  logic [rd_data_width-1:0] tail_data;
  logic                     tail_valid;

  logic                     pop;
  logic [1:0]               occ;
  logic                     space_ok;
  logic                     issue;
  logic                     seg_end;
  logic                     drain_done;
  logic                     ws_last;
  logic                     wrap;
  logic [addr_width-1:0]    step_addr;
  logic [4:0]               step_ws;

  assign pop = head_valid & bus.dout_ready;

  // Buffered plus in-flight samples. A sample popped this cycle frees its
  // slot before the read issued now returns, so it is credited here; that is
  // what lets a steady ready stream run at one sample per cycle.
  assign occ      = {1'b0, head_valid} + {1'b0, tail_valid} + {1'b0, rd_pending};
  assign space_ok = (occ - {1'b0, pop}) < 2'd2;

  assign ws_last = (rd_ws == WS_MAX);
  assign wrap    = (state == SEG_A) && ws_last && (rd_addr == a_last);

  always_comb begin
    step_addr = rd_addr;
    step_ws   = rd_ws + 5'd1;
    if (wrap) begin
      step_addr = '0;
      step_ws   = '0;
    end else if (ws_last) begin
      step_addr = rd_addr + addr_width'(1);
      step_ws   = '0;
    end
  end

  always_comb begin
    state_n    = state;
    issue      = 1'b0;
    seg_end    = 1'b0;
    drain_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (seg_a_len != 32'd0)      state_n = SEG_A;
          else if (seg_b_len != 32'd0) state_n = SEG_B;
        end
      end
      SEG_A: begin
        if (space_ok) begin
          issue = 1'b1;
          if (remaining == 32'd1) begin
            seg_end = 1'b1;
            state_n = (b_len != 32'd0) ? SEG_B : DRAIN;
          end
        end
      end
      SEG_B: begin
        if (space_ok) begin
          issue = 1'b1;
          if (remaining == 32'd1) begin
            seg_end = 1'b1;
            state_n = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Last read already landed in the buffer; finish on its acceptance
        if (!rd_pending && !tail_valid && pop) begin
          drain_done = 1'b1;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_addr    <= '0;
      rd_ws      <= '0;
      a_last     <= '0;
      b_addr     <= '0;
      b_len      <= '0;
      remaining  <= '0;
      rd_pending <= 1'b0;
      head_data  <= '0;
      head_valid <= 1'b0;
      tail_data  <= '0;
      tail_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      rd_pending <= issue;
      done       <= 1'b0;

      if (state == IDLE && start) begin
        a_last <= seg_a_last;
        b_addr <= seg_b_addr;
        b_len  <= seg_b_len;
        if (seg_a_len != 32'd0) begin
          rd_addr   <= seg_a_addr;
          rd_ws     <= seg_a_ws;
          remaining <= seg_a_len;
          busy      <= 1'b1;
        end else if (seg_b_len != 32'd0) begin
          rd_addr   <= seg_b_addr;
          rd_ws     <= '0;
          remaining <= seg_b_len;
          busy      <= 1'b1;
        end else begin
          done <= 1'b1;
        end
      end

      if (issue) begin
        if (seg_end && state == SEG_A && b_len != 32'd0) begin
          // Chain straight into B so its first read can issue next cycle
          rd_addr   <= b_addr;
          rd_ws     <= '0;
          remaining <= b_len;
        end else begin
          rd_addr   <= step_addr;
          rd_ws     <= step_ws;
          remaining <= remaining - 32'd1;
        end
      end

      if (drain_done) begin
        done <= 1'b1;
        busy <= 1'b0;
      end

      case ({rd_pending, pop})
        2'b01: begin
          if (tail_valid) head_data <= tail_data;
          head_valid <= tail_valid;
          tail_valid <= 1'b0;
        end
        2'b10: begin
          if (!head_valid) begin
            head_data  <= bus.bram_rd_data;
            head_valid <= 1'b1;
          end else begin
            tail_data  <= bus.bram_rd_data;
            tail_valid <= 1'b1;
          end
        end
        2'b11: begin
          if (tail_valid) begin
            head_data <= tail_data;
            tail_data <= bus.bram_rd_data;
          end else begin
            head_data <= bus.bram_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.bram_rd_addr = rd_addr;
  assign bus.bram_rd_ws   = rd_ws;
  assign bus.bram_rd_ce   = issue;
  assign bus.dout         = head_data;
  assign bus.dout_valid   = head_valid;

endmodule

// File: tb/tb_varwidth_fifo_reader.sv
// tb/tb_varwidth_fifo_reader.sv - scoreboard bench for varwidth_fifo_reader
module tb_varwidth_fifo_reader;
  localparam int AW = 11;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] seg_a_addr = '0;
  logic [4:0]    seg_a_ws = '0;
  logic [AW-1:0] seg_a_last = '0;
  logic [31:0]   seg_a_len = '0;
  logic [AW-1:0] seg_b_addr = '0;
  logic [31:0]   seg_b_len = '0;
  logic          busy;
  logic          done;

  varwidth_fifo_reader_if #(.addr_width(AW), .rd_data_width(DW)) bus ();

  varwidth_fifo_reader #(.addr_width(AW), .rd_data_width(DW), .rd_data_per_addr(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .seg_a_addr (seg_a_addr),
    .seg_a_ws   (seg_a_ws),
    .seg_a_last (seg_a_last),
    .seg_a_len  (seg_a_len),
    .seg_b_addr (seg_b_addr),
    .seg_b_len  (seg_b_len),
    .bus        (bus),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] ram_val(input logic [AW-1:0] a, input logic [4:0] w);
    logic [12:0] t;
    t = {a, 2'b00} + {8'b0, w};
    return t[7:0];
  endfunction

  // RAM model: 1-cycle read latency
  always @(posedge clk)
    if (bus.bram_rd_ce) bus.bram_rd_data <= ram_val(bus.bram_rd_addr, bus.bram_rd_ws);

  // Scoreboard queues: expected pushed at start, observed filled by the monitor
  logic [15:0] exp_rd[$];
  logic [7:0]  exp_dout[$];
  logic [15:0] obs_rd[$];
  int          obs_rd_cyc[$];
  logic [7:0]  obs_dout[$];
  int          obs_acc_cyc[$];
  int          done_cnt, done_cyc, first_valid_cyc, start_cyc;
  int          outstanding, max_out, stall_viol;
  bit          busy_seen, prev_stall;
  logic [7:0]  prev_dout;

  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 0;
      prev_stall  = 0;
    end else begin
      if (bus.bram_rd_ce) begin
        obs_rd.push_back({bus.bram_rd_addr, bus.bram_rd_ws});
        obs_rd_cyc.push_back(cyc);
        outstanding++;
      end
      if (prev_stall && (!bus.dout_valid || bus.dout !== prev_dout)) stall_viol++;
      prev_stall = bus.dout_valid && !bus.dout_ready;
      prev_dout  = bus.dout;
      if (bus.dout_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.dout_valid && bus.dout_ready) begin
        obs_dout.push_back(bus.dout);
        obs_acc_cyc.push_back(cyc);
        outstanding--;
      end
      if (outstanding > max_out) max_out = outstanding;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_seen = 1;
    end
  end

  task automatic clear_obs();
    exp_rd.delete(); exp_dout.delete();
    obs_rd.delete(); obs_rd_cyc.delete(); obs_dout.delete(); obs_acc_cyc.delete();
    done_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
    max_out = 0; stall_viol = 0; busy_seen = 0; prev_stall = 0;
  endtask

  task automatic pulse_start(input logic [AW-1:0] aa, input logic [4:0] aw, input logic [AW-1:0] al,
                             input int alen, input logic [AW-1:0] ba, input int blen, input bit push_exp);
    logic [AW-1:0] a;
    logic [4:0]    w;
    @(posedge clk); #1;
    seg_a_addr = aa; seg_a_ws = aw; seg_a_last = al; seg_a_len = alen;
    seg_b_addr = ba; seg_b_len = blen;
    start = 1'b1;
    start_cyc = cyc;
    if (push_exp) begin
      a = aa; w = aw;
      for (int i = 0; i < alen; i++) begin
        exp_rd.push_back({a, w}); exp_dout.push_back(ram_val(a, w));
        if (w == 5'd3) begin
          a = (a == al) ? '0 : a + 1'b1;
          w = '0;
        end else w = w + 1'b1;
      end
      a = ba; w = '0;
      for (int i = 0; i < blen; i++) begin
        exp_rd.push_back({a, w}); exp_dout.push_back(ram_val(a, w));
        if (w == 5'd3) begin
          a = a + 1'b1;
          w = '0;
        end else w = w + 1'b1;
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: random ready with periodic 10-cycle stalls
  task automatic run(input string tag, input int mode, input int max_cyc);
    for (int i = 0; i < max_cyc && done_cnt == 0; i++) begin
      @(posedge clk); #1;
      if (mode == 1)
        bus.dout_ready = ((i % 40) >= 10 && (i % 40) < 20) ? 1'b0 : 1'($urandom_range(0, 1));
    end
    bus.dout_ready = 1'b1;
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL %s timeout: no done within %0d cycles", tag, max_cyc);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.bram_rd_ce, bus.dout_valid, busy, done} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl got ce/valid/busy/done=%b required 0000",
               {bus.bram_rd_ce, bus.dout_valid, busy, done});
    end
    checks++;
    if ({bus.bram_rd_addr, bus.bram_rd_ws} !== 16'h0) begin
      errors++;
      $display("FAIL reset_addr got %h required 0000", {bus.bram_rd_addr, bus.bram_rd_ws});
    end
    checks++;
    if (bus.dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_dout got %h required 00", bus.dout);
    end
  endtask

  task automatic test_basic();
    clear_obs();
    bus.dout_ready = 1'b1;
    pulse_start(11'd5, 5'd2, 11'd7, 10, 11'd0, 0, 1);
    run("basic", 0, 200);
    checks++;
    if (obs_rd.size() != exp_rd.size()) begin errors++; $display("FAIL basic_nrd got %0d required %0d", obs_rd.size(), exp_rd.size()); end
    foreach (exp_rd[i]) if (i < obs_rd.size()) begin
      checks++;
      if (obs_rd[i] !== exp_rd[i]) begin errors++; $display("FAIL basic_rd[%0d] got %h required %h", i, obs_rd[i], exp_rd[i]); end
    end
    checks++;
    if (obs_dout.size() != exp_dout.size()) begin errors++; $display("FAIL basic_nout got %0d required %0d", obs_dout.size(), exp_dout.size()); end
    foreach (exp_dout[i]) if (i < obs_dout.size()) begin
      checks++;
      if (obs_dout[i] !== exp_dout[i]) begin errors++; $display("FAIL basic_dout[%0d] got %h required %h", i, obs_dout[i], exp_dout[i]); end
    end
    checks++;
    if (first_valid_cyc - start_cyc != 3) begin errors++; $display("FAIL basic_latency got %0d required 3", first_valid_cyc - start_cyc); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL basic_done_cnt got %0d required 1", done_cnt); end
    if (obs_acc_cyc.size() == 10) begin
      checks++;
      if (obs_acc_cyc[9] - obs_acc_cyc[0] != 9) begin errors++; $display("FAIL basic_throughput got span %0d required 9", obs_acc_cyc[9] - obs_acc_cyc[0]); end
      checks++;
      if (done_cyc - obs_acc_cyc[9] != 1) begin errors++; $display("FAIL basic_done_time got %0d required 1", done_cyc - obs_acc_cyc[9]); end
    end
  endtask

  task automatic test_wrap_chain();
    clear_obs();
    bus.dout_ready = 1'b1;
    pulse_start(11'd7, 5'd3, 11'd7, 3, 11'd8, 5, 1);
    run("wrap", 0, 200);
    checks++;
    if (obs_rd.size() != exp_rd.size()) begin errors++; $display("FAIL wrap_nrd got %0d required %0d", obs_rd.size(), exp_rd.size()); end
    foreach (exp_rd[i]) if (i < obs_rd.size()) begin
      checks++;
      if (obs_rd[i] !== exp_rd[i]) begin errors++; $display("FAIL wrap_rd[%0d] got %h required %h", i, obs_rd[i], exp_rd[i]); end
    end
    checks++;
    if (obs_dout.size() != 8) begin errors++; $display("FAIL wrap_nout got %0d required 8", obs_dout.size()); end
    foreach (exp_dout[i]) if (i < obs_dout.size()) begin
      checks++;
      if (obs_dout[i] !== exp_dout[i]) begin errors++; $display("FAIL wrap_dout[%0d] got %h required %h", i, obs_dout[i], exp_dout[i]); end
    end
    if (obs_rd_cyc.size() == 8) begin
      checks++;
      if (obs_rd_cyc[7] - obs_rd_cyc[0] != 7) begin errors++; $display("FAIL wrap_no_gap got span %0d required 7", obs_rd_cyc[7] - obs_rd_cyc[0]); end
    end
  endtask

  task automatic test_backpressure();
    clear_obs();
    bus.dout_ready = 1'b0;
    pulse_start(11'd0, 5'd0, 11'd200, 100, 11'd0, 0, 1);
    run("backpressure", 1, 3000);
    checks++;
    if (obs_dout.size() != 100) begin errors++; $display("FAIL bp_nout got %0d required 100", obs_dout.size()); end
    foreach (exp_dout[i]) if (i < obs_dout.size()) begin
      checks++;
      if (obs_dout[i] !== exp_dout[i]) begin errors++; $display("FAIL bp_dout[%0d] got %h required %h", i, obs_dout[i], exp_dout[i]); end
    end
    checks++;
    if (stall_viol != 0) begin errors++; $display("FAIL bp_stable got %0d changes during stall required 0", stall_viol); end
    checks++;
    if (max_out > 2) begin errors++; $display("FAIL bp_outstanding got %0d required <=2", max_out); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL bp_done_cnt got %0d required 1", done_cnt); end
  endtask

  task automatic test_zero_len();
    clear_obs();
    bus.dout_ready = 1'b1;
    pulse_start(11'd3, 5'd1, 11'd9, 0, 11'd20, 4, 1);
    run("zero_a", 0, 100);
    checks++;
    if (obs_rd.size() != 4) begin errors++; $display("FAIL zero_a_nrd got %0d required 4", obs_rd.size()); end
    foreach (exp_rd[i]) if (i < obs_rd.size()) begin
      checks++;
      if (obs_rd[i] !== exp_rd[i]) begin errors++; $display("FAIL zero_a_rd[%0d] got %h required %h", i, obs_rd[i], exp_rd[i]); end
    end
    clear_obs();
    pulse_start(11'd3, 5'd1, 11'd9, 0, 11'd20, 0, 1);
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (obs_rd.size() != 0) begin errors++; $display("FAIL zero_both_nrd got %0d required 0", obs_rd.size()); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL zero_both_done_cnt got %0d required 1", done_cnt); end
    checks++;
    if (done_cyc - start_cyc != 1) begin errors++; $display("FAIL zero_both_done_time got %0d required 1", done_cyc - start_cyc); end
    checks++;
    if (busy_seen) begin errors++; $display("FAIL zero_both_busy got 1 required 0"); end
  endtask

  task automatic test_reset_mid();
    int i;
    clear_obs();
    bus.dout_ready = 1'b1;
    pulse_start(11'd0, 5'd0, 11'd200, 20, 11'd0, 0, 1);
    for (i = 0; i < 200 && obs_dout.size() < 6; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (obs_dout.size() < 6) begin errors++; $display("FAIL rst_mid_reach got %0d samples required 6", obs_dout.size()); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.bram_rd_ce, bus.dout_valid, busy, done} !== 4'b0) begin
      errors++;
      $display("FAIL rst_mid_ctrl got ce/valid/busy/done=%b required 0000", {bus.bram_rd_ce, bus.dout_valid, busy, done});
    end
    checks++;
    if ({bus.bram_rd_addr, bus.bram_rd_ws, bus.dout} !== 24'h0) begin
      errors++;
      $display("FAIL rst_mid_data got %h required 000000", {bus.bram_rd_addr, bus.bram_rd_ws, bus.dout});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL rst_mid_no_done got %0d required 0", done_cnt); end
    clear_obs();
    pulse_start(11'd0, 5'd0, 11'd200, 20, 11'd0, 0, 1);
    run("rst_mid_replay", 0, 200);
    checks++;
    if (obs_dout.size() != 20) begin errors++; $display("FAIL rst_mid_nout got %0d required 20", obs_dout.size()); end
    foreach (exp_dout[k]) if (k < obs_dout.size()) begin
      checks++;
      if (obs_dout[k] !== exp_dout[k]) begin errors++; $display("FAIL rst_mid_dout[%0d] got %h required %h", k, obs_dout[k], exp_dout[k]); end
    end
  endtask

  task automatic test_start_busy();
    clear_obs();
    bus.dout_ready = 1'b1;
    pulse_start(11'd5, 5'd2, 11'd7, 10, 11'd0, 0, 1);
    repeat (2) @(posedge clk);
    pulse_start(11'd40, 5'd1, 11'd90, 30, 11'd50, 7, 0);
    run("start_busy", 0, 200);
    checks++;
    if (obs_rd.size() != exp_rd.size()) begin errors++; $display("FAIL sb_nrd got %0d required %0d", obs_rd.size(), exp_rd.size()); end
    foreach (exp_rd[i]) if (i < obs_rd.size()) begin
      checks++;
      if (obs_rd[i] !== exp_rd[i]) begin errors++; $display("FAIL sb_rd[%0d] got %h required %h", i, obs_rd[i], exp_rd[i]); end
    end
    foreach (exp_dout[i]) if (i < obs_dout.size()) begin
      checks++;
      if (obs_dout[i] !== exp_dout[i]) begin errors++; $display("FAIL sb_dout[%0d] got %h required %h", i, obs_dout[i], exp_dout[i]); end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL sb_done_cnt got %0d required 1", done_cnt); end
  endtask

  initial begin
    bus.dout_ready = 1'b0;
    clear_obs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_wrap_chain();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
    test_start_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
